// File: rtl/apb_master_nslv.sv
// Buffered APB master: a command FIFO feeds back-to-back transfers to one of NS slaves.
// Optional ACCESS-phase timeout is compiled in when APB_TIMEOUT_EN is defined.
module apb_master_nslv #(
    parameter int DW = 32,
    parameter int AW = 8,
    parameter int NS = 4,
    parameter int FD = 4,
    parameter int TO = 16,
    localparam int SW   = DW / 8,
    localparam int SB   = (NS > 1) ? $clog2(NS) : 1,
    localparam int CW   = 1 + SW + DW + AW,
    localparam int RW   = 1 + DW,
    localparam int CNTW = $clog2(FD) + 1
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic [CW-1:0]    i_cmd,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [RW-1:0]    o_resp,
    output logic             o_resp_valid,
    output logic             o_busy,
    output logic [CNTW-1:0]  o_fifo_cnt,
    output logic [AW-1:0]    o_paddr,
    output logic             o_pwrite,
    output logic [NS-1:0]    o_psel,
    output logic             o_penable,
    output logic [DW-1:0]    o_pwdata,
    output logic [SW-1:0]    o_pstrb,
    input  logic [NS*DW-1:0] i_prdata,
    input  logic [NS-1:0]    i_pslverr,
    input  logic [NS-1:0]    i_pready
);

    localparam int PW = $clog2(FD);
    localparam logic [SB:0] NS_L = (SB + 1)'(NS);

    if (DW % 8 != 0 || AW <= $clog2(NS) || NS < 1 || NS > 16 ||
        FD < 2 || (FD & (FD - 1)) != 0 || TO < 2) begin : g_param_chk
        $error("apb_master_nslv: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   mem_q [FD];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [CNTW-1:0] cnt_q;
    logic            push, pop, empty;
    logic [CW-1:0]   head;
    logic [SB-1:0]   head_idx, idx_q;
    logic            head_bad;

    logic [AW-1:0]   paddr_q;
    logic            pwrite_q, penable_q, resp_valid_q;
    logic [DW-1:0]   pwdata_q;
    logic [SW-1:0]   pstrb_q;
    logic [NS-1:0]   psel_q;
    logic [RW-1:0]   resp_q;

    logic            sel_ready, sel_err, tmo_hit, xfer_end;
    logic [DW-1:0]   sel_rdata, rdata_m;

    assign o_ready    = (cnt_q != CNTW'(FD));
    assign empty      = (cnt_q == '0);
    assign push       = i_valid && o_ready;
    assign head       = mem_q[rptr_q];
    assign o_fifo_cnt = cnt_q;
    assign o_busy     = (state_q != IDLE) || !empty;

    if (NS > 1) begin : g_idx
        assign head_idx = head[AW-1 -: SB];
    end else begin : g_idx1
        assign head_idx = '0;
    end
    assign head_bad = ({1'b0, head_idx} >= NS_L);

    // Pointers wrap naturally because FD is a power of two.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + CNTW'(push) - CNTW'(pop);
        end
    end

    always_ff @(posedge pclk) begin
        if (push) mem_q[wptr_q] <= i_cmd;
    end

    assign sel_ready = i_pready[idx_q];
    assign sel_err   = i_pslverr[idx_q];
    assign sel_rdata = i_prdata[idx_q*DW +: DW];
    assign rdata_m   = pwrite_q ? '0 : sel_rdata;

`ifdef APB_TIMEOUT_EN
    localparam int TOW = $clog2(TO) + 1;
    logic [TOW-1:0] tmo_q;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset)                tmo_q <= '0;
        else if (state_q != ACCESS) tmo_q <= '0;
        else if (!sel_ready)        tmo_q <= tmo_q + 1'b1;
    end

    // A pready in the final cycle takes priority over the timeout.
    assign tmo_hit = (state_q == ACCESS) && !sel_ready && (tmo_q == TOW'(TO - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    assign xfer_end = (state_q == ERR) || ((state_q == ACCESS) && (sel_ready || tmo_hit));

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = head_bad ? ERR : SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS, ERR: begin
                if (xfer_end) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = head_bad ? ERR : SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            paddr_q      <= '0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            psel_q       <= '0;
            penable_q    <= 1'b0;
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= xfer_end;
            if (xfer_end) begin
                resp_q <= ((state_q == ACCESS) && sel_ready) ? {sel_err, rdata_m}
                                                             : {1'b1, {DW{1'b0}}};
            end
            if (pop) begin
                idx_q    <= head_idx;
                paddr_q  <= head[AW-1:0];
                pwdata_q <= head[AW +: DW];
                pwrite_q <= head[CW-1];
                pstrb_q  <= head[CW-1] ? head[AW+DW +: SW] : '0;
            end
            if (state_d == SETUP)       psel_q <= NS'(1) << head_idx;
            else if (state_d != ACCESS) psel_q <= '0;
            penable_q <= (state_d == ACCESS);
        end
    end

    assign o_paddr      = paddr_q;
    assign o_pwrite     = pwrite_q;
    assign o_pwdata     = pwdata_q;
    assign o_pstrb      = pstrb_q;
    assign o_psel       = psel_q;
    assign o_penable    = penable_q;
    assign o_resp       = resp_q;
    assign o_resp_valid = resp_valid_q;

endmodule

// File: tb/tb_apb_master_nslv.sv
// Bench for apb_master_nslv: directed vectors, FIFO-full / reset-abort / bad-index
// sequences, and a randomized run against a queue-based transaction model.
module tb_apb_master_nslv;

    localparam int DW = 32;
    localparam int NS = 4;
    localparam int CW = 45;

    typedef struct packed {
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [7:0]  addr;
    } cmd_t;

    typedef struct {
        cmd_t        c;
        int          wt;
        logic [31:0] rd;
        logic        err;
        logic [3:0]  exp_psel;
        logic [32:0] exp_resp;
    } vec_t;

    logic           pclk = 1'b0;
    logic           preset;
    logic [CW-1:0]  i_cmd;
    logic           i_valid;
    logic           o_ready, o_resp_valid, o_busy, o_pwrite, o_penable;
    logic [32:0]    o_resp;
    logic [2:0]     o_fifo_cnt;
    logic [7:0]     o_paddr;
    logic [3:0]     o_psel, o_pstrb;
    logic [31:0]    o_pwdata;
    logic [NS*DW-1:0] i_prdata;
    logic [NS-1:0]  i_pslverr, i_pready;

    logic [CW-1:0]  d3_cmd;
    logic           d3_valid, d3_ready, d3_resp_valid, d3_busy, d3_pwrite, d3_penable;
    logic [32:0]    d3_resp;
    logic [2:0]     d3_fifo_cnt;
    logic [7:0]     d3_paddr;
    logic [2:0]     d3_psel, d3_pslverr, d3_pready;
    logic [31:0]    d3_pwdata;
    logic [3:0]     d3_pstrb;
    logic [95:0]    d3_prdata;

    assign d3_pready  = 3'b111;
    assign d3_pslverr = 3'b000;
    assign d3_prdata  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

    always #5 pclk = ~pclk;

    apb_master_nslv u_dut (
        .pclk(pclk), .preset(preset), .i_cmd(i_cmd), .i_valid(i_valid),
        .o_ready(o_ready), .o_resp(o_resp), .o_resp_valid(o_resp_valid),
        .o_busy(o_busy), .o_fifo_cnt(o_fifo_cnt), .o_paddr(o_paddr),
        .o_pwrite(o_pwrite), .o_psel(o_psel), .o_penable(o_penable),
        .o_pwdata(o_pwdata), .o_pstrb(o_pstrb), .i_prdata(i_prdata),
        .i_pslverr(i_pslverr), .i_pready(i_pready)
    );

    apb_master_nslv #(.NS(3)) u_dut3 (
        .pclk(pclk), .preset(preset), .i_cmd(d3_cmd), .i_valid(d3_valid),
        .o_ready(d3_ready), .o_resp(d3_resp), .o_resp_valid(d3_resp_valid),
        .o_busy(d3_busy), .o_fifo_cnt(d3_fifo_cnt), .o_paddr(d3_paddr),
        .o_pwrite(d3_pwrite), .o_psel(d3_psel), .o_penable(d3_penable),
        .o_pwdata(d3_pwdata), .o_pstrb(d3_pstrb), .i_prdata(d3_prdata),
        .i_pslverr(d3_pslverr), .i_pready(d3_pready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    cmd_t        issue_q[$];
    logic [32:0] exp_q[$];

    bit          rnd_mode = 1'b0;
    int          tbl_wait = 0;
    logic [31:0] tbl_rd   = '0;
    logic        tbl_err  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] hrd(input logic [7:0] a);
        return {a, ~a, a ^ 8'h5A, 8'h3C};
    endfunction

    function automatic logic herr(input logic [7:0] a);
        return a[0] ^ a[2];
    endfunction

    function automatic logic [32:0] exp_tbl(input cmd_t c);
        return {tbl_err, c.wr ? 32'h0 : tbl_rd};
    endfunction

    // Slave bank: unselected slaves babble random values that must be ignored.
    int          acc_cyc = 0;
    int          want    = 0;
    int          sidx;
    always @(negedge pclk) begin
        i_pready  = 4'($urandom) & ~o_psel;
        i_pslverr = 4'($urandom);
        for (int k = 0; k < NS; k++) i_prdata[k*DW +: DW] = $urandom;
        if (o_penable && o_psel != 0) begin
            sidx = 0;
            for (int k = 0; k < NS; k++) if (o_psel[k]) sidx = k;
            if (!rnd_mode)          want = tbl_wait;
            else if (acc_cyc == 0)  want = $urandom_range(0, 3);
            i_pready[sidx]          = (acc_cyc >= want);
            i_prdata[sidx*DW +: DW] = rnd_mode ? hrd(o_paddr) : tbl_rd;
            i_pslverr[sidx]         = rnd_mode ? herr(o_paddr) : tbl_err;
            acc_cyc++;
        end else begin
            acc_cyc = 0;
        end
    end

    // Protocol and scoreboard monitor for the main instance.
    cmd_t        mc;
    logic [44:0] held;
    always @(negedge pclk) begin
        if (!preset) begin
            chk("psel_onehot0", 64'($onehot0(o_psel)), 1);
            if (o_penable) chk("penable_without_psel", 64'(o_psel != 0), 1);
            if (o_psel != 0 && !o_penable) begin
                chk("setup_expected", 64'(issue_q.size() != 0), 1);
                if (issue_q.size() != 0) begin
                    mc = issue_q.pop_front();
                    chk("setup_fields", {o_pwrite, o_pstrb, o_pwdata, o_paddr},
                        {mc.wr, mc.wr ? mc.strb : 4'h0, mc.wdata, mc.addr});
                    chk("setup_psel", o_psel, 4'b0001 << mc.addr[7:6]);
                end
                held = {o_pwrite, o_pstrb, o_pwdata, o_paddr};
            end
            if (o_penable) chk("access_hold", {o_pwrite, o_pstrb, o_pwdata, o_paddr}, held);
            if (o_resp_valid) begin
                chk("resp_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("resp_value", o_resp, exp_q.pop_front());
            end
        end
    end

    task automatic drive_push(input cmd_t c, input logic [32:0] er, output bit acc);
        @(negedge pclk);
        i_cmd   = c;
        i_valid = 1'b1;
        acc     = o_ready;
        if (acc) begin
            issue_q.push_back(c);
            exp_q.push_back(er);
        end
        @(posedge pclk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, o_ready, 1);
        chk({tag, "_outs"}, {o_resp_valid, o_resp, o_busy, o_fifo_cnt, o_psel,
                             o_penable, o_pwrite, o_pstrb}, 0);
        chk({tag, "_bus"}, {o_paddr, o_pwdata}, 0);
    endtask

    // Pushes one command into an idle DUT and times it; negedge 2 is SETUP.
    task automatic run_one(input cmd_t c, input logic [32:0] er, input int wt,
                           input logic [3:0] epsel, input string tag);
        bit acc;
        int lat;
        bit got;
        drive_push(c, er, acc);
        chk({tag, "_accept"}, acc, 1);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 64) begin
            @(negedge pclk);
            lat++;
            if (lat == 2) chk({tag, "_setup"}, {o_penable, o_psel}, {1'b0, epsel});
            if (lat == 3) chk({tag, "_access"}, {o_penable, o_psel}, {1'b1, epsel});
            if (o_resp_valid) got = 1'b1;
        end
        chk({tag, "_latency"}, got ? 64'(lat) : 64'hFFFF, 64'(wt + 4));
        if (got) begin
            chk({tag, "_resp"}, o_resp, er);
            chk({tag, "_idle_bus"}, {o_penable, o_psel}, 0);
        end
    endtask

    vec_t        tbl[5];
    cmd_t        c;
    bit          acc;
    int          npulse, cyc, nacc;
    int          rt[$];
    logic [32:0] r3[2];
    logic [2:0]  psel_or;
    bit          got;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        preset   = 1'b1;
        i_valid  = 1'b0;
        i_cmd    = '0;
        d3_valid = 1'b0;
        d3_cmd   = '0;

        tbl[0] = '{c: '{1'b1, 4'hF, 32'hA5A5_A5A5, 8'h04}, wt: 0, rd: 32'hDEAD_BEEF,
                   err: 1'b0, exp_psel: 4'b0001, exp_resp: {1'b0, 32'h0}};
        tbl[1] = '{c: '{1'b0, 4'hF, 32'h0, 8'hC8}, wt: 3, rd: 32'h1234_5678,
                   err: 1'b0, exp_psel: 4'b1000, exp_resp: {1'b0, 32'h1234_5678}};
        tbl[2] = '{c: '{1'b0, 4'h0, 32'h0, 8'h45}, wt: 1, rd: 32'hCAFE_F00D,
                   err: 1'b1, exp_psel: 4'b0010, exp_resp: {1'b1, 32'hCAFE_F00D}};
        tbl[3] = '{c: '{1'b1, 4'h3, 32'h0000_BEEF, 8'h80}, wt: 2, rd: 32'h5555_AAAA,
                   err: 1'b1, exp_psel: 4'b0100, exp_resp: {1'b1, 32'h0}};
        tbl[4] = '{c: '{1'b0, 4'h5, 32'h1111_2222, 8'h7F}, wt: 0, rd: 32'hFFFF_FFFF,
                   err: 1'b0, exp_psel: 4'b0010, exp_resp: {1'b0, 32'hFFFF_FFFF}};

        repeat (2) @(negedge pclk);
        chk_reset_state("reset");
        chk("reset_d3", {d3_ready, d3_busy, d3_fifo_cnt, d3_psel, d3_resp_valid}, 64'h100);
        preset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            tbl_wait = tbl[i].wt;
            tbl_rd   = tbl[i].rd;
            tbl_err  = tbl[i].err;
            run_one(tbl[i].c, tbl[i].exp_resp, tbl[i].wt, tbl[i].exp_psel, $sformatf("vec%0d", i));
        end

        // FIFO full: first command stalls in ACCESS while five more are offered.
        tbl_wait = 1000;
        tbl_rd   = 32'h0BAD_F00D;
        tbl_err  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            c = cmd_t'({$urandom_range(0, 1), 4'($urandom), 32'($urandom), 8'($urandom)});
            drive_push(c, exp_tbl(c), acc);
            chk("fill_accept", acc, 1);
        end
        chk("fill_cnt", o_fifo_cnt, 4);
        chk("fill_ready", o_ready, 0);
        c = cmd_t'({1'b0, 4'hF, 32'h0, 8'h10});
        drive_push(c, exp_tbl(c), acc);
        chk("fill_drop", acc, 0);
        tbl_wait = 0;
        rt.delete();
        for (cyc = 0; cyc < 40; cyc++) begin
            @(negedge pclk);
            if (o_resp_valid) rt.push_back(cyc);
        end
        chk("fill_resp_count", rt.size(), 5);
        if (rt.size() == 5)
            for (int i = 1; i < 5; i++) chk($sformatf("fill_gap%0d", i), rt[i] - rt[i-1], 2);
        chk("fill_idle", {o_busy, o_fifo_cnt}, 0);

        // Reset asserted mid-ACCESS with two commands queued.
        tbl_wait = 1000;
        for (int i = 0; i < 3; i++) begin
            c = cmd_t'({1'b0, 4'h0, 32'h0, 8'(8'h20 + i)});
            drive_push(c, exp_tbl(c), acc);
        end
        chk("abort_pre_cnt", o_fifo_cnt, 2);
        chk("abort_pre_access", o_penable, 1);
        @(negedge pclk);
        #2;
        preset = 1'b1;
        #1;
        chk_reset_state("abort");
        issue_q.delete();
        exp_q.delete();
        @(negedge pclk);
        preset   = 1'b0;
        tbl_wait = 0;
        npulse   = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge pclk);
            if (o_resp_valid) npulse++;
        end
        chk("abort_no_resp", npulse, 0);
        tbl_rd = 32'h7777_0001;
        run_one(cmd_t'({1'b0, 4'h0, 32'h0, 8'h41}), {1'b0, 32'h7777_0001}, 0, 4'b0010, "post_abort");

        // NS = 3: index 3 has no slave, the following command must still complete.
        @(negedge pclk);
        d3_cmd   = {1'b0, 4'hF, 32'h0, 8'hC0};
        d3_valid = 1'b1;
        @(posedge pclk);
        #1;
        d3_cmd = {1'b0, 4'hF, 32'h0, 8'h40};
        @(posedge pclk);
        #1;
        d3_valid = 1'b0;
        npulse   = 0;
        psel_or  = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge pclk);
            psel_or |= d3_psel;
            if (d3_resp_valid) begin
                if (npulse < 2) r3[npulse] = d3_resp;
                npulse++;
            end
        end
        chk("ns3_resp_count", npulse, 2);
        if (npulse == 2) begin
            chk("ns3_err_resp", r3[0], {1'b1, 32'h0});
            chk("ns3_next_resp", r3[1], {1'b0, 32'h2222_2222});
        end
        chk("ns3_psel_seen", psel_or, 3'b010);
        chk("ns3_idle", d3_busy, 0);

`ifdef APB_TIMEOUT_EN
        // Slave never ready: transfer is cut off after 16 ACCESS cycles.
        tbl_wait = 1000;
        c = cmd_t'({1'b0, 4'h0, 32'h0, 8'h90});
        drive_push(c, {1'b1, 32'h0}, acc);
        nacc = 0;
        got  = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge pclk);
            if (o_penable) nacc++;
            if (o_resp_valid) got = 1'b1;
        end
        chk("tmo_access_cycles", nacc, 16);
        chk("tmo_resp", {got, o_resp}, {1'b1, 1'b1, 32'h0});
        chk("tmo_psel_dropped", {o_penable, o_psel}, 0);

        // pready on the 16th ACCESS cycle beats the timeout.
        tbl_wait = 15;
        tbl_rd   = 32'h600D_D00D;
        tbl_err  = 1'b0;
        c = cmd_t'({1'b0, 4'h0, 32'h0, 8'h91});
        drive_push(c, {1'b0, 32'h600D_D00D}, acc);
        nacc = 0;
        got  = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge pclk);
            if (o_penable) nacc++;
            if (o_resp_valid) got = 1'b1;
        end
        chk("tmo_late_cycles", nacc, 16);
        chk("tmo_late_resp", {got, o_resp}, {1'b1, 1'b0, 32'h600D_D00D});
`endif

        // Randomized traffic with random wait states.
        rnd_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge pclk);
            c       = cmd_t'({$urandom_range(0, 1), 4'($urandom), 32'($urandom), 8'($urandom)});
            i_cmd   = c;
            i_valid = ($urandom_range(0, 2) != 0);
            if (i_valid && o_ready) begin
                issue_q.push_back(c);
                exp_q.push_back({herr(c.addr), c.wr ? 32'h0 : hrd(c.addr)});
            end
        end
        @(negedge pclk);
        i_valid = 1'b0;
        for (int i = 0; i < 400 && (exp_q.size() != 0 || o_busy); i++) @(negedge pclk);
        chk("drain_resp_left", exp_q.size(), 0);
        chk("drain_setup_left", issue_q.size(), 0);
        chk("drain_busy", o_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
